// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the reaction-game pattern path.
//   state_t        : pattern sequencer states
//   PATTERN_W      : width of the target pattern
//   LFSR_MASK      : Galois feedback mask for the 16-bit right-shifting LFSR
//   FALLBACK_A/B   : substitutes used when the raw LFSR byte is unusable
//   lfsr_step      : one LFSR shift
//   pick_candidate : turns a raw LFSR byte into a usable, non-repeating pattern
// ----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2
    } state_t;

    localparam int                   PATTERN_W  = 8;
    localparam logic [15:0]          LFSR_MASK  = 16'hB400;
    localparam logic [PATTERN_W-1:0] FALLBACK_A = 8'h01;
    localparam logic [PATTERN_W-1:0] FALLBACK_B = 8'h02;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // Score logic downstream cannot handle a blank target or the same target
    // twice in a row, so either case is replaced by a fallback that differs
    // from the previous pattern.
    function automatic logic [PATTERN_W-1:0] pick_candidate(
        input logic [PATTERN_W-1:0] raw,
        input logic [PATTERN_W-1:0] prev
    );
        if ((raw == '0) || (raw == prev)) begin
            return (prev == FALLBACK_A) ? FALLBACK_B : FALLBACK_A;
        end
        return raw;
    endfunction

endpackage

// File: rtl/pattern_generator_if.sv
// ----------------------------------------------------------------------------
// pattern_generator_if
// Signal bundle between the pattern generator and the score side.
//   enable        : level, 1 = game running            (score side -> generator)
//   hit           : 1-cycle pulse, pattern matched      (score side -> generator)
//   counter10h    : 1-cycle game tick pulse             (generator -> score side)
//   pattern       : current target, 0 = nothing shown   (generator -> score side)
//   pattern_valid : high while a pattern is shown       (generator -> score side)
//   round_count   : patterns issued, wraps at 256       (generator -> score side)
// ----------------------------------------------------------------------------
interface pattern_generator_if;
    import game_pkg::*;

    logic                 enable;
    logic                 hit;
    logic                 counter10h;
    logic [PATTERN_W-1:0] pattern;
    logic                 pattern_valid;
    logic [7:0]           round_count;

    modport master (
        input  enable,
        input  hit,
        output counter10h,
        output pattern,
        output pattern_valid,
        output round_count
    );

    modport slave (
        output enable,
        output hit,
        input  counter10h,
        input  pattern,
        input  pattern_valid,
        input  round_count
    );
endinterface

// File: rtl/tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler
// Divides the system clock down to a game tick. While enable is high the
// counter runs 0..DIV-1 and a registered one-cycle tick follows each wrap, so
// the first tick arrives DIV clocks after enable rises. Dropping enable clears
// the counter and suppresses the tick.
//   CLOCK50M : system clock
//   reset_n  : asynchronous active-low reset
//   enable   : run the divider
//   tick     : one-cycle pulse every DIV clocks
// ----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 10
) (
    input  logic CLOCK50M,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);
    localparam int               DIV      = CLK_HZ / TICK_HZ;
    localparam int               PRE_W    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;

    always_comb begin
        pre_d  = '0;
        tick_d = 1'b0;
        if (enable) begin
            if (pre_q == PRE_LAST) begin
                tick_d = 1'b1;
            end else begin
                pre_d = pre_q + PRE_ONE;
            end
        end
    end

    always_ff @(posedge CLOCK50M or negedge reset_n) begin
        if (!reset_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/pattern_generator.sv
// ----------------------------------------------------------------------------
// pattern_generator
// Produces the game tick and the sequence of 8-bit target patterns: each
// pattern is held for SHOW_TICKS ticks, followed by GAP_TICKS blank ticks.
// A hit pulse while a pattern is shown ends it at once and starts a gap.
//   CLOCK50M : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : pattern_generator_if.master (enable, hit in;
//              counter10h, pattern, pattern_valid, round_count out)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | game stopped, nothing shown
// GAP   | blank between patterns, cnt counts remaining gap ticks
// SHOW  | pattern displayed, cnt counts remaining show ticks
// ----------------------------------------------------------------------------
module pattern_generator
    import game_pkg::*;
#(
    parameter int          CLK_HZ     = 50_000_000,
    parameter int          TICK_HZ    = 10,
    parameter int          SHOW_TICKS = 10,
    parameter int          GAP_TICKS  = 5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                CLOCK50M,
    input  logic                reset_n,
    pattern_generator_if.master bus
);
    localparam int CNT_MAX   = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int CNT_W_RAW = $clog2(CNT_MAX + 1);
    localparam int CNT_W     = (CNT_W_RAW < 4) ? 4 : CNT_W_RAW;

    localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(SHOW_TICKS);
    localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PATTERN_W-1:0] pattern_q, pattern_d;
    logic [PATTERN_W-1:0] prev_q, prev_d;
    logic [7:0]           round_q, round_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic                 tick;
    logic [PATTERN_W-1:0] cand;

    tick_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_prescaler (
        .CLOCK50M (CLOCK50M),
        .reset_n  (reset_n),
        .enable   (bus.enable),
        .tick     (tick)
    );

    // Free-running so the sequence depends on how long the player waited.
    assign lfsr_d = lfsr_step(lfsr_q);
    assign cand   = pick_candidate(lfsr_q[PATTERN_W-1:0], prev_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pattern_d = pattern_q;
        prev_d    = prev_q;
        round_d   = round_q;

        if (!bus.enable) begin
            state_d   = IDLE;
            pattern_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = GAP;
                    cnt_d     = CNT_GAP;
                    pattern_d = '0;
                end
                GAP: begin
                    if (tick) begin
                        if (cnt_q == CNT_ONE) begin
                            state_d   = SHOW;
                            cnt_d     = CNT_SHOW;
                            pattern_d = cand;
                            prev_d    = cand;
                            round_d   = round_q + 8'd1;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
                SHOW: begin
                    // hit has priority; a coinciding tick is swallowed so the
                    // following gap is always a full GAP_TICKS long.
                    if (bus.hit) begin
                        state_d   = GAP;
                        cnt_d     = CNT_GAP;
                        pattern_d = '0;
                    end else if (tick) begin
                        if (cnt_q == CNT_ONE) begin
                            state_d   = GAP;
                            cnt_d     = CNT_GAP;
                            pattern_d = '0;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    pattern_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pattern_q <= '0;
            prev_q    <= '0;
            round_q   <= '0;
            lfsr_q    <= LFSR_SEED;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
            prev_q    <= prev_d;
            round_q   <= round_d;
            lfsr_q    <= lfsr_d;
        end
    end

    assign bus.counter10h    = tick;
    assign bus.pattern       = pattern_q;
    assign bus.pattern_valid = (state_q == SHOW);
    assign bus.round_count   = round_q;

endmodule

// File: tb/tb_pattern_generator.sv
// ----------------------------------------------------------------------------
// tb_pattern_generator
// Directed bench for pattern_generator with DIV = 10, SHOW = 3, GAP = 2 ticks.
// ----------------------------------------------------------------------------
module tb_pattern_generator;

    localparam int          CLK_HZ     = 100;
    localparam int          TICK_HZ    = 10;
    localparam int          SHOW_TICKS = 3;
    localparam int          GAP_TICKS  = 2;
    localparam logic [15:0] SEED       = 16'hACE1;

    logic CLOCK50M = 1'b0;
    logic reset_n;

    int n_checks = 0;
    int n_errors = 0;

    pattern_generator_if bus ();

    pattern_generator #(
        .CLK_HZ     (CLK_HZ),
        .TICK_HZ    (TICK_HZ),
        .SHOW_TICKS (SHOW_TICKS),
        .GAP_TICKS  (GAP_TICKS),
        .LFSR_SEED  (SEED)
    ) dut (
        .CLOCK50M (CLOCK50M),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 CLOCK50M = ~CLOCK50M;

    // Reference LFSR, tracks the value the DUT holds during each cycle.
    function automatic logic [15:0] ref_next(input logic [15:0] v);
        logic [15:0] r;
        r = {1'b0, v[15:1]};
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic logic [15:0] ref_adv(input logic [15:0] v, input int n);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = ref_next(r);
        return r;
    endfunction

    function automatic logic [7:0] exp_pick(input logic [7:0] a, input logic [7:0] prev);
        if (a == 8'h00 || a == prev) return (prev == 8'h01) ? 8'h02 : 8'h01;
        return a;
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge CLOCK50M or negedge reset_n) begin
        if (!reset_n) m_lfsr <= SEED;
        else          m_lfsr <= ref_next(m_lfsr);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLOCK50M);
    endtask

    // Wait until raising enable now makes the first issue see the wanted raw
    // LFSR byte (issue uses the value 20 clocks after enable is sampled).
    task automatic launch_for(input string tag, input logic [7:0] target);
        logic [15:0] l20;
        bit          found;
        int          zero_bad;
        found = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            l20 = ref_adv(m_lfsr, 20);
            if (l20[7:0] == target) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check_eq({tag, "_search"}, 32'(found), 32'd1);
        bus.enable = 1'b1;
        zero_bad = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus.pattern != 8'h00) zero_bad++;
        end
        check_eq({tag, "_blank_before"}, 32'(zero_bad), 32'd0);
        step();
    endtask

    logic [15:0] l20v;
    logic [7:0]  pred, prev_iss, cur_pat, p, last_l;
    int          first_tick, second_tick, zero_bad, ticks, run_len, n_iss;
    int          bad_hold, bad_gap, bad_diff, bad_pred, bad_valid;

    initial begin
        bus.enable = 1'b0;
        bus.hit    = 1'b0;
        reset_n    = 1'b0;
        repeat (3) step();

        check_eq("rst_pattern", 32'(bus.pattern), 32'd0);
        check_eq("rst_valid",   32'(bus.pattern_valid), 32'd0);
        check_eq("rst_round",   32'(bus.round_count), 32'd0);
        check_eq("rst_tick",    32'(bus.counter10h), 32'd0);
        check_eq("rst_lfsr",    32'(dut.lfsr_q), 32'h0000ACE1);

        reset_n = 1'b1;
        step();
        step();
        check_eq("lfsr_two_steps", 32'(dut.lfsr_q), 32'(ref_adv(SEED, 2)));

        // First launch: tick timing and first issue.
        l20v = ref_adv(m_lfsr, 20);
        pred = exp_pick(l20v[7:0], 8'h00);
        bus.enable  = 1'b1;
        first_tick  = -1;
        second_tick = -1;
        zero_bad    = 0;
        for (int i = 1; i <= 21; i++) begin
            step();
            if (bus.counter10h) begin
                if (first_tick < 0) first_tick = i;
                else if (second_tick < 0) second_tick = i;
            end
            if (i <= 20 && bus.pattern != 8'h00) zero_bad++;
        end
        check_eq("first_tick_at",   32'(first_tick), 32'd10);
        check_eq("second_tick_at",  32'(second_tick), 32'd20);
        check_eq("first_gap_blank", 32'(zero_bad), 32'd0);
        check_eq("first_pattern",   32'(bus.pattern), 32'(pred));
        check_eq("first_valid",     32'(bus.pattern_valid), 32'd1);
        check_eq("first_round",     32'(bus.round_count), 32'd1);

        // Free run to 50 issued patterns.
        cur_pat  = bus.pattern;
        prev_iss = bus.pattern;
        last_l   = m_lfsr[7:0];
        run_len  = 1;
        n_iss    = 1;
        bad_hold = 0; bad_gap = 0; bad_diff = 0; bad_pred = 0; bad_valid = 0;
        for (int k = 0; k < 3000 && n_iss < 50; k++) begin
            step();
            p = bus.pattern;
            if (bus.pattern_valid !== (p != 8'h00)) bad_valid++;
            if (p == cur_pat) begin
                run_len++;
            end else begin
                if (cur_pat != 8'h00) begin
                    if (run_len != 30) bad_hold++;
                end else begin
                    if (run_len != 20) bad_gap++;
                end
                if (p != 8'h00) begin
                    if (cur_pat != 8'h00) bad_diff++;
                    if (p == prev_iss) bad_diff++;
                    if (p != exp_pick(last_l, prev_iss)) bad_pred++;
                    prev_iss = p;
                    n_iss++;
                end
                cur_pat = p;
                run_len = 1;
            end
            last_l = m_lfsr[7:0];
        end
        check_eq("free_issued",    32'(n_iss), 32'd50);
        check_eq("free_hold_len",  32'(bad_hold), 32'd0);
        check_eq("free_gap_len",   32'(bad_gap), 32'd0);
        check_eq("free_distinct",  32'(bad_diff), 32'd0);
        check_eq("free_lfsr_pick", 32'(bad_pred), 32'd0);
        check_eq("free_valid",     32'(bad_valid), 32'd0);
        check_eq("free_round",     32'(bus.round_count), 32'd50);

        // Hit 5 clocks into SHOW.
        repeat (4) step();
        bus.hit = 1'b1;
        step();
        bus.hit = 1'b0;
        check_eq("hit_blank",    32'(bus.pattern), 32'd0);
        check_eq("hit_valid",    32'(bus.pattern_valid), 32'd0);
        zero_bad = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (bus.pattern != 8'h00) zero_bad++;
        end
        check_eq("hit_gap_blank", 32'(zero_bad), 32'd0);
        step();
        check_eq("hit_next_shown",   32'(bus.pattern != 8'h00), 32'd1);
        check_eq("hit_next_differs", 32'(bus.pattern != prev_iss), 32'd1);
        check_eq("hit_next_round",   32'(bus.round_count), 32'd51);

        // Hit on the tick that ends SHOW; hit during GAP is ignored.
        repeat (29) step();
        check_eq("end_tick_present", 32'(bus.counter10h), 32'd1);
        check_eq("end_still_shown",  32'(bus.pattern_valid), 32'd1);
        bus.hit = 1'b1;
        step();
        bus.hit = 1'b0;
        check_eq("end_hit_blank", 32'(bus.pattern), 32'd0);
        check_eq("end_hit_round", 32'(bus.round_count), 32'd51);
        repeat (4) step();
        bus.hit = 1'b1;
        step();
        bus.hit = 1'b0;
        zero_bad = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (bus.pattern != 8'h00) zero_bad++;
        end
        check_eq("end_gap_full", 32'(zero_bad), 32'd0);
        step();
        check_eq("end_next_shown", 32'(bus.pattern != 8'h00), 32'd1);
        check_eq("end_next_round", 32'(bus.round_count), 32'd52);
        prev_iss = bus.pattern;

        // Enable low mid-SHOW.
        repeat (3) step();
        bus.enable = 1'b0;
        step();
        check_eq("dis_pattern", 32'(bus.pattern), 32'd0);
        check_eq("dis_valid",   32'(bus.pattern_valid), 32'd0);
        ticks    = 0;
        zero_bad = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus.counter10h) ticks++;
            if (bus.pattern != 8'h00) zero_bad++;
        end
        check_eq("dis_no_ticks", 32'(ticks), 32'd0);
        check_eq("dis_blank",    32'(zero_bad), 32'd0);
        check_eq("dis_round",    32'(bus.round_count), 32'd52);

        // Candidate selection corner cases via timed relaunches.
        launch_for("raw37", 8'h37);
        check_eq("raw37_pattern", 32'(bus.pattern), 32'(exp_pick(8'h37, prev_iss)));
        check_eq("raw37_round",   32'(bus.round_count), 32'd53);
        bus.enable = 1'b0;
        repeat (2) step();

        launch_for("raw00", 8'h00);
        check_eq("raw00_pattern", 32'(bus.pattern), 32'h01);
        check_eq("raw00_round",   32'(bus.round_count), 32'd54);
        bus.enable = 1'b0;
        repeat (2) step();

        launch_for("raw01", 8'h01);
        check_eq("raw01_pattern", 32'(bus.pattern), 32'h02);
        check_eq("raw01_round",   32'(bus.round_count), 32'd55);
        bus.enable = 1'b0;
        repeat (2) step();

        // Asynchronous reset mid-GAP, observed before the next clock edge.
        bus.enable = 1'b1;
        repeat (5) step();
        check_eq("pre_rst_round", 32'(bus.round_count), 32'd55);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("arst_round",   32'(bus.round_count), 32'd0);
        check_eq("arst_lfsr",    32'(dut.lfsr_q), 32'h0000ACE1);
        check_eq("arst_pattern", 32'(bus.pattern), 32'd0);
        check_eq("arst_valid",   32'(bus.pattern_valid), 32'd0);
        bus.enable = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
